// File: rtl/decoder_buf.sv
// decoder_buf: binary codes enter a small FIFO on a valid/ready stream and leave as
// one-hot words on a second valid/ready stream; a saturating counter tracks delivered words.
module decoder_buf #(
    parameter int CODE_W = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        flush_in,
    input  logic [CODE_W-1:0]           code_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [(32'd1<<CODE_W)-1:0]  onehot_out,
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [$clog2(DEPTH):0]      level_out,
    output logic [CNT_W-1:0]            count_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int OUT_W = 32'd1 << CODE_W;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    function automatic logic [OUT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] word;
        word       = '0;
        word[code] = 1'b1;
        return word;
    endfunction

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_s, pop_s;

    // Handshake flags derive only from registered occupancy, never from valid_in/ready_in.
    assign ready_out  = (level_q != FULL_LVL);
    assign valid_out  = (level_q != '0);
    assign push_s     = valid_in && ready_out;
    assign pop_s      = valid_out && ready_in;
    assign level_out  = level_q;
    assign count_out  = count_q;
    assign onehot_out = valid_out ? decode_onehot(mem_q[rd_ptr_q]) : '0;

    // Next-state for pointers, occupancy and delivered-word counter; flush overrides both sides.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LVL_W'(1'b1);
                2'b01:   level_d = level_q - LVL_W'(1'b1);
                default: level_d = level_q;
            endcase
            if (pop_s && (count_q != '1)) begin
                count_d = count_q + CNT_W'(1'b1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
        end
    end

    // Code storage; contents after reset are irrelevant because level gates every read.
    always_ff @(posedge clk_in) begin
        if (push_s && !flush_in) begin
            mem_q[wr_ptr_q] <= code_in;
        end
    end
endmodule

// File: tb/tb_decoder_buf.sv
// Directed bench for decoder_buf: an 8-bit-counter instance and a 3-bit-counter
// instance share all inputs so saturation is observable alongside normal counting.
module tb_decoder_buf;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] code = 2'd0;
    logic       vin = 1'b0;
    logic       rdy = 1'b0;
    logic       ready_o, valid_o, ready_o3, valid_o3;
    logic [3:0] onehot_o, onehot_o3;
    logic [1:0] level_o, level_o3;
    logic [7:0] count8;
    logic [2:0] count3;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decoder_buf #(.CODE_W(2), .DEPTH(2), .CNT_W(8)) dut (
        .clk_in(clk), .rst_in(rst), .flush_in(flush), .code_in(code), .valid_in(vin),
        .ready_out(ready_o), .onehot_out(onehot_o), .valid_out(valid_o), .ready_in(rdy),
        .level_out(level_o), .count_out(count8));

    decoder_buf #(.CODE_W(2), .DEPTH(2), .CNT_W(3)) dut_s (
        .clk_in(clk), .rst_in(rst), .flush_in(flush), .code_in(code), .valid_in(vin),
        .ready_out(ready_o3), .onehot_out(onehot_o3), .valid_out(valid_o3), .ready_in(rdy),
        .level_out(level_o3), .count_out(count3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vin = 1'b1; code = 2'd2; rdy = 1'b0;
        step(); step();
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
        total++; if (onehot_o !== 4'b0000) begin bad++; $display("FAIL reset_onehot got=%b exp=0000", onehot_o); end
        total++; if (count8 !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count8); end
        total++; if (level_o !== 2'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_o); end
        vin = 1'b0; rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            code = 2'(i); vin = 1'b1;
            step();
            exp = 4'b0001 << i;
            total++; if (onehot_o !== exp) begin bad++; $display("FAIL b2b_onehot[%0d] got=%b exp=%b", i, onehot_o, exp); end
            total++; if (level_o !== 2'd1) begin bad++; $display("FAIL b2b_level[%0d] got=%0d exp=1", i, level_o); end
        end
        vin = 1'b0;
        step();
        total++; if (level_o !== 2'd0) begin bad++; $display("FAIL b2b_drain_level got=%0d exp=0", level_o); end
        total++; if (count8 !== 8'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", count8); end
    endtask

    task automatic test_backpressure();
        rdy = 1'b0; vin = 1'b1;
        code = 2'd3; step();
        code = 2'd1; step();
        total++; if (level_o !== 2'd2) begin bad++; $display("FAIL bp_level got=%0d exp=2", level_o); end
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b exp=0", ready_o); end
        code = 2'd2; step();
        total++; if (level_o !== 2'd2) begin bad++; $display("FAIL bp_refused_level got=%0d exp=2", level_o); end
        vin = 1'b0; rdy = 1'b1;
        total++; if (onehot_o !== 4'b1000) begin bad++; $display("FAIL bp_first got=%b exp=1000", onehot_o); end
        step();
        total++; if (onehot_o !== 4'b0010) begin bad++; $display("FAIL bp_second got=%b exp=0010", onehot_o); end
        step();
        total++; if (onehot_o !== 4'b0000 || level_o !== 2'd0) begin bad++; $display("FAIL bp_empty onehot=%b level=%0d exp=0000/0", onehot_o, level_o); end
        total++; if (count8 !== 8'd6) begin bad++; $display("FAIL bp_count got=%0d exp=6", count8); end
    endtask

    task automatic test_full_simul();
        logic [3:0] exp;
        rdy = 1'b0; vin = 1'b1;
        code = 2'd0; step();
        code = 2'd1; step();
        code = 2'd2; rdy = 1'b1;
        step();
        total++; if (level_o !== 2'd1) begin bad++; $display("FAIL full_pop_level got=%0d exp=1", level_o); end
        total++; if (onehot_o !== 4'b0010) begin bad++; $display("FAIL full_pop_head got=%b exp=0010", onehot_o); end
        for (int i = 0; i < 12; i++) begin
            code = 2'((i * 3 + 1) % 4);
            step();
            exp = 4'b0001 << code;
            total++; if (level_o !== 2'd1 || onehot_o !== exp) begin bad++; $display("FAIL wrap[%0d] level=%0d onehot=%b exp=1/%b", i, level_o, onehot_o, exp); end
        end
        vin = 1'b0;
        step();
        total++; if (level_o !== 2'd0) begin bad++; $display("FAIL wrap_drain got=%0d exp=0", level_o); end
        total++; if (count8 !== 8'd20) begin bad++; $display("FAIL wrap_count got=%0d exp=20", count8); end
    endtask

    task automatic test_flush();
        rdy = 1'b0; vin = 1'b1;
        code = 2'd2; step();
        code = 2'd3; step();
        flush = 1'b1; code = 2'd1; rdy = 1'b1;
        step();
        flush = 1'b0;
        total++; if (level_o !== 2'd0 || valid_o !== 1'b0 || onehot_o !== 4'b0000) begin bad++; $display("FAIL flush_state level=%0d valid=%0b onehot=%b exp=0/0/0000", level_o, valid_o, onehot_o); end
        total++; if (count8 !== 8'd20) begin bad++; $display("FAIL flush_count got=%0d exp=20", count8); end
        rdy = 1'b0; code = 2'd1;
        step();
        total++; if (level_o !== 2'd1 || onehot_o !== 4'b0010) begin bad++; $display("FAIL flush_repush level=%0d onehot=%b exp=1/0010", level_o, onehot_o); end
        vin = 1'b0; rdy = 1'b1;
        step();
        total++; if (count8 !== 8'd21) begin bad++; $display("FAIL flush_after_count got=%0d exp=21", count8); end
    endtask

    task automatic test_saturate();
        logic [2:0] exp;
        rst = 1'b1; #2; rst = 1'b0;
        total++; if (count3 !== 3'd0) begin bad++; $display("FAIL sat_reset got=%0d exp=0", count3); end
        rdy = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            vin = (j <= 9);
            code = 2'(j % 4);
            step();
            exp = (j - 1 > 7) ? 3'd7 : 3'(j - 1);
            total++; if (count3 !== exp) begin bad++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", j, count3, exp); end
        end
        total++; if (count8 !== 8'd9) begin bad++; $display("FAIL sat_wide_count got=%0d exp=9", count8); end
    endtask

    task automatic test_async_reset();
        rdy = 1'b0; vin = 1'b1;
        code = 2'd1; step(); step();
        total++; if (level_o !== 2'd2) begin bad++; $display("FAIL ar_pre_level got=%0d exp=2", level_o); end
        #3; rst = 1'b1; #1;
        total++; if (level_o !== 2'd0 || valid_o !== 1'b0 || onehot_o !== 4'b0000 || ready_o !== 1'b1) begin bad++; $display("FAIL ar_state level=%0d valid=%0b onehot=%b ready=%0b exp=0/0/0000/1", level_o, valid_o, onehot_o, ready_o); end
        total++; if (count8 !== 8'd0 || count3 !== 3'd0) begin bad++; $display("FAIL ar_count c8=%0d c3=%0d exp=0/0", count8, count3); end
        step();
        rst = 1'b0; code = 2'd3;
        step();
        total++; if (level_o !== 2'd1 || onehot_o !== 4'b1000) begin bad++; $display("FAIL ar_first_push level=%0d onehot=%b exp=1/1000", level_o, onehot_o); end
        vin = 1'b0; rdy = 1'b1;
        step();
        total++; if (level_o !== 2'd0 || count8 !== 8'd1) begin bad++; $display("FAIL ar_drain level=%0d count=%0d exp=0/1", level_o, count8); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_full_simul();
        test_flush();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
